mac_cluster_sequencer: RTL

- Job-level controller in front of one mac_cluster instance.
- Accepts a job (config word plus beat count) and pulses cset to load the config.
- Streams operand beats into the cluster under valid/ready, then flushes the cluster pipeline with zero operands.
- Captures the four accumulators and returns them on a result valid/ready port. Replaces hand-driven cset/en sequencing at cluster level.

---
 rtl/mac_seq_pkg.sv | 39 +++
 rtl/mac_cluster_sequencer_if.sv | 35 +++
 rtl/mac_seq_beat_counter.sv | 30 +++
 rtl/mac_cluster_sequencer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types and layout constants for the MAC cluster job sequencer:
// state encoding, cfg word field offsets and operand lane packing.
package mac_seq_pkg;

  localparam int MAC_CONF_WIDTH = 4;
  localparam int MAC_MIN_WIDTH  = 8;
  localparam int MAC_ACC_WIDTH  = 32;
  localparam int CFG_WIDTH      = 4*MAC_ACC_WIDTH + MAC_CONF_WIDTH;
  localparam int CNT_WIDTH      = 16;
  localparam int LATENCY        = 2;
  localparam int OP_WIDTH       = 8*MAC_MIN_WIDTH;
  localparam int RES_WIDTH      = 4*MAC_ACC_WIDTH;
  localparam int DRN_WIDTH      = $clog2(LATENCY+1);

  localparam int CFG_MODE_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

  // cfg word is {init3,init2,init1,init0,mode}
  function automatic int cfg_init_lsb(input int k);
    return MAC_CONF_WIDTH + k*MAC_ACC_WIDTH;
  endfunction

  // operand word is {B3,B2,B1,B0,A3,A2,A1,A0}
  function automatic int op_a_lsb(input int k);
    return k*MAC_MIN_WIDTH;
  endfunction

  function automatic int op_b_lsb(input int k);
    return (4+k)*MAC_MIN_WIDTH;
  endfunction

endpackage

// File: rtl/mac_cluster_sequencer_if.sv
// Job, operand, cluster and result signals of the sequencer; slave is the
// sequencer side, master is the job source / cluster / result sink side.
interface mac_cluster_sequencer_if;
  import mac_seq_pkg::*;

  logic                 job_valid;
  logic                 job_ready;
  logic [CFG_WIDTH-1:0] job_cfg;
  logic [CNT_WIDTH-1:0] job_len;
  logic                 op_valid;
  logic                 op_ready;
  logic [OP_WIDTH-1:0]  op_data;
  logic                 mac_cset;
  logic                 mac_en;
  logic [CFG_WIDTH-1:0] mac_cfg;
  logic [OP_WIDTH-1:0]  mac_ops;
  logic [RES_WIDTH-1:0] mac_out;
  logic                 res_valid;
  logic                 res_ready;
  logic [RES_WIDTH-1:0] res_data;
  logic                 busy;

  modport slave (
    input  job_valid, job_cfg, job_len, op_valid, op_data, mac_out, res_ready,
    output job_ready, op_ready, mac_cset, mac_en, mac_cfg, mac_ops,
           res_valid, res_data, busy
  );

  modport master (
    output job_valid, job_cfg, job_len, op_valid, op_data, mac_out, res_ready,
    input  job_ready, op_ready, mac_cset, mac_en, mac_cfg, mac_ops,
           res_valid, res_data, busy
  );

endinterface

// File: rtl/mac_seq_beat_counter.sv
// Loadable down-counter with zero flag; load wins over decrement, and a
// decrement at zero is ignored so the count never wraps.
module mac_seq_beat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mac_cluster_sequencer.sv
// Job sequencer for one mac_cluster: cset, stream len beats, LATENCY-cycle flush, hold result
// until res_ready; job latency 2+len+LATENCY cycles. Optional MAC_SEQ_PERF_EN adds stall/job counters.
module mac_cluster_sequencer
  import mac_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  mac_cluster_sequencer_if.slave bus
`ifdef MAC_SEQ_PERF_EN
  ,
  output logic [31:0] perf_stall,
  output logic [15:0] perf_jobs
`endif
);

  seq_state_t           r_state;
  logic [CFG_WIDTH-1:0] r_cfg;
  logic [RES_WIDTH-1:0] r_res;
  logic                 r_res_vld;

  logic                 w_idle;
  logic                 w_run;
  logic                 w_drain;
  logic                 w_job_acc;
  logic                 w_beat_acc;
  logic [CNT_WIDTH-1:0] w_beat_cnt;
  logic                 w_beat_zero;
  logic                 w_beat_last;
  logic [DRN_WIDTH-1:0] w_drain_cnt;
  logic                 w_drain_zero;
  logic                 w_drain_last;

  assign w_idle      = rst_n & (r_state == ST_IDLE);
  assign w_run       = (r_state == ST_RUN);
  assign w_drain     = (r_state == ST_DRAIN);
  assign w_job_acc   = w_idle & bus.job_valid;
  assign w_beat_acc  = w_run & bus.op_valid;
  assign w_beat_last = (w_beat_cnt == CNT_WIDTH'(1));
  assign w_drain_last = (w_drain_cnt == DRN_WIDTH'(1));

  mac_seq_beat_counter #(.W(CNT_WIDTH)) u_beat_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_job_acc),
    .i_load_val (bus.job_len),
    .i_dec      (w_beat_acc),
    .o_cnt      (w_beat_cnt),
    .o_zero     (w_beat_zero)
  );

  // Held at LATENCY outside DRAIN so every drain starts from a full count.
  mac_seq_beat_counter #(.W(DRN_WIDTH)) u_drain_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (!w_drain),
    .i_load_val (DRN_WIDTH'(LATENCY)),
    .i_dec      (w_drain),
    .o_cnt      (w_drain_cnt),
    .o_zero     (w_drain_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cfg     <= '0;
      r_res     <= '0;
      r_res_vld <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.job_valid) begin
            r_cfg   <= bus.job_cfg;
            r_state <= ST_CONFIG;
          end
        end
        ST_CONFIG: r_state <= w_beat_zero ? ST_DRAIN : ST_RUN;
        ST_RUN: begin
          if (bus.op_valid && w_beat_last) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_drain_last) begin
            r_res     <= bus.mac_out;
            r_res_vld <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            r_res_vld <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.job_ready = w_idle;
  assign bus.op_ready  = w_run;
  assign bus.mac_cset  = (r_state == ST_CONFIG);
  // Idle RUN cycles freeze the cluster so no bubble enters the accumulators.
  assign bus.mac_en    = (w_run & bus.op_valid) | (w_drain & ~w_drain_zero);
  assign bus.mac_ops   = w_run ? bus.op_data : '0;
  assign bus.mac_cfg   = r_cfg;
  assign bus.res_valid = r_res_vld;
  assign bus.res_data  = r_res;
  assign bus.busy      = (r_state != ST_IDLE);

`ifdef MAC_SEQ_PERF_EN
  logic [31:0] r_perf_stall;
  logic [15:0] r_perf_jobs;
  logic        w_stall_evt;
  logic        w_job_evt;

  assign w_stall_evt = (w_run & ~bus.op_valid) | ((r_state == ST_DONE) & ~bus.res_ready);
  assign w_job_evt   = (r_state == ST_DONE) & bus.res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_jobs  <= '0;
    end else begin
      if (w_stall_evt && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
      if (w_job_evt && (r_perf_jobs != '1))    r_perf_jobs  <= r_perf_jobs + 16'd1;
    end
  end

  assign perf_stall = r_perf_stall;
  assign perf_jobs  = r_perf_jobs;
`endif

endmodule
